// File: rtl/mips_pkg.sv
// Shared types and defaults for the MEM pipeline stage.
package mips_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 15;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request bus: valid/ready style, req is the valid and ack is the
// ready; a beat completes in any cycle where both are high.
interface mem_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: IDLE/WAIT FSM with a wait counter that abandons
// an access after TIMEOUT_CYCLES unacknowledged WAIT cycles.
module mem_access_fsm
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   memop_i,
    input  logic   misalign_i,
    input  logic   ack_i,
    output logic   req_o,
    output logic   stall_o,
    output logic   accept_o,
    output logic   abort_o,
    output logic   mem_error_o,
    output state_t state_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_error_q;
    logic             in_wait;
    logic             timeout;
    logic             illegal;

    assign in_wait  = (state_q == WAIT);
    assign timeout  = in_wait & ~ack_i & (cnt_q == CNT_LAST);
    assign illegal  = ~in_wait & memop_i & misalign_i;

    // Gated by rst_n so no request is visible while reset is held.
    assign req_o    = rst_n & (in_wait | (memop_i & ~misalign_i));
    // Timeout lets the held instruction retire as a bubble, so stall drops.
    assign stall_o  = req_o & ~ack_i & ~timeout;
    assign accept_o = req_o & ack_i;
    assign abort_o  = timeout | illegal;

    assign mem_error_o = mem_error_q;
    assign state_o     = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_error_q <= 1'b0;
        end else begin
            if (abort_o) begin
                mem_error_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (req_o && !ack_i) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    if (ack_i || timeout) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access, branch/jump redirect and MEM/WB registers.
// Define MEM_ALIGN_CHECK_EN to reject word-unaligned loads/stores.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_Jump,
    input  logic        in_Branch,
    input  logic        in_MemRead,
    input  logic        in_MemtoReg,
    input  logic        in_MemWrite,
    input  logic        in_RegWrite,
    input  logic [27:0] in_JumpAddress,
    input  logic [31:0] in_AddFour,
    input  logic [31:0] in_Adder,
    input  logic [31:0] in_ALU,
    input  logic [31:0] in_ReadData2,
    input  logic        in_Zero,
    input  logic [4:0]  in_WriteRegister,
    mem_stage_if.master dmem,
    output logic        stall,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        out_RegWrite,
    output logic        out_MemtoReg,
    output logic [31:0] out_ReadData,
    output logic [31:0] out_ALU,
    output logic [4:0]  out_WriteRegister,
    output logic        mem_error,
    output state_t      dbg_state
);

    logic memop;
    logic misalign;
    logic req;
    logic accept;
    logic abort;
    logic unused_addfour;

    assign memop = in_MemRead | in_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (in_ALU[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    mem_access_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .memop_i     (memop),
        .misalign_i  (misalign),
        .ack_i       (dmem.dmem_ack),
        .req_o       (req),
        .stall_o     (stall),
        .accept_o    (accept),
        .abort_o     (abort),
        .mem_error_o (mem_error),
        .state_o     (dbg_state)
    );

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = in_MemWrite;
    assign dmem.dmem_addr  = in_ALU;
    assign dmem.dmem_wdata = in_ReadData2;

    assign pc_redirect = rst_n & ((in_Branch & in_Zero) | in_Jump) & ~stall;
    assign pc_target   = in_Jump ? {in_AddFour[31:28], in_JumpAddress} : in_Adder;

    assign unused_addfour = ^in_AddFour[27:0];

    // An aborted access still retires, but as a bubble that writes nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_RegWrite      <= 1'b0;
            out_MemtoReg      <= 1'b0;
            out_ReadData      <= '0;
            out_ALU           <= '0;
            out_WriteRegister <= '0;
        end else if (!stall) begin
            out_RegWrite      <= in_RegWrite & ~abort;
            out_MemtoReg      <= in_MemtoReg & ~abort;
            out_ALU           <= in_ALU;
            out_WriteRegister <= in_WriteRegister;
            if (accept) begin
                out_ReadData <= dmem.dmem_rdata;
            end
        end else begin
            out_RegWrite <= 1'b0;
            out_MemtoReg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage with a MEM/WB scoreboard queue.
module tb_mem_stage;
    import mips_pkg::*;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_Jump, in_Branch, in_MemRead, in_MemtoReg, in_MemWrite, in_RegWrite;
    logic [27:0] in_JumpAddress;
    logic [31:0] in_AddFour, in_Adder, in_ALU, in_ReadData2;
    logic        in_Zero;
    logic [4:0]  in_WriteRegister;
    logic        stall, pc_redirect, out_RegWrite, out_MemtoReg, mem_error;
    logic [31:0] pc_target, out_ReadData, out_ALU;
    logic [4:0]  out_WriteRegister;
    state_t      dbg_state;

    mem_stage_if dmem_bus();

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_Jump(in_Jump), .in_Branch(in_Branch), .in_MemRead(in_MemRead),
        .in_MemtoReg(in_MemtoReg), .in_MemWrite(in_MemWrite), .in_RegWrite(in_RegWrite),
        .in_JumpAddress(in_JumpAddress), .in_AddFour(in_AddFour), .in_Adder(in_Adder),
        .in_ALU(in_ALU), .in_ReadData2(in_ReadData2), .in_Zero(in_Zero),
        .in_WriteRegister(in_WriteRegister), .dmem(dmem_bus),
        .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .out_RegWrite(out_RegWrite), .out_MemtoReg(out_MemtoReg),
        .out_ReadData(out_ReadData), .out_ALU(out_ALU),
        .out_WriteRegister(out_WriteRegister), .mem_error(mem_error), .dbg_state(dbg_state)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    logic [70:0] exp_q[$];
    logic [31:0] model_rd = '0;
    logic        exp_err = 1'b0;

    task automatic clear_inputs();
        in_Jump = 0; in_Branch = 0; in_MemRead = 0; in_MemtoReg = 0; in_MemWrite = 0;
        in_RegWrite = 0; in_JumpAddress = '0; in_AddFour = '0; in_Adder = '0; in_ALU = '0;
        in_ReadData2 = '0; in_Zero = 0; in_WriteRegister = '0;
        dmem_bus.dmem_ack = 0; dmem_bus.dmem_rdata = '0;
    endtask

    // Drives one instruction until the model says it retires; ack_dly < 0 means no ack.
    task automatic run_instr(input logic mr, input logic mw, input logic rw, input logic m2r,
                             input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                             input int ack_dly, input logic [31:0] rd, output int stalls);
        logic memop, legal, ack, tmo, abort, e_req, e_stall, e_redir;
        logic [31:0] e_tgt;
        logic [70:0] e_out, got;
        int k;
        in_MemRead = mr; in_MemWrite = mw; in_RegWrite = rw; in_MemtoReg = m2r;
        in_ALU = alu; in_ReadData2 = wd; in_WriteRegister = wr; dmem_bus.dmem_rdata = rd;
        memop = mr | mw;
        legal = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
        legal = (alu[1:0] == 2'b00);
`endif
        stalls = 0;
        k = 0;
        e_stall = 1'b0;
        do begin
            ack = (ack_dly >= 0) && (k == ack_dly);
            dmem_bus.dmem_ack = ack;
            e_req   = memop && legal;
            tmo     = e_req && !ack && (k == TO);
            abort   = tmo || (memop && !legal);
            e_stall = e_req && !ack && !tmo;
            e_redir = ((in_Branch & in_Zero) | in_Jump) && !e_stall;
            e_tgt   = in_Jump ? {in_AddFour[31:28], in_JumpAddress} : in_Adder;
            @(negedge clk);
            n_tests++;
            if (dmem_bus.dmem_req !== e_req) begin
                n_fail++; $display("FAIL req k=%0d got=%b exp=%b", k, dmem_bus.dmem_req, e_req);
            end
            n_tests++;
            if (stall !== e_stall) begin
                n_fail++; $display("FAIL stall k=%0d got=%b exp=%b", k, stall, e_stall);
            end
            n_tests++;
            if ({dmem_bus.dmem_we, dmem_bus.dmem_wdata, dmem_bus.dmem_addr} !== {mw, wd, alu}) begin
                n_fail++; $display("FAIL bus we/wdata/addr got=%b/%h/%h exp=%b/%h/%h", dmem_bus.dmem_we,
                                   dmem_bus.dmem_wdata, dmem_bus.dmem_addr, mw, wd, alu);
            end
            n_tests++;
            if ({pc_redirect, pc_target} !== {e_redir, e_tgt}) begin
                n_fail++; $display("FAIL redirect got=%b/%h exp=%b/%h", pc_redirect, pc_target, e_redir, e_tgt);
            end
            n_tests++;
            if (mem_error !== exp_err) begin
                n_fail++; $display("FAIL mem_error got=%b exp=%b", mem_error, exp_err);
            end
            if (!e_stall) begin
                if (e_req && ack) model_rd = rd;
                exp_q.push_back({rw & ~abort, m2r & ~abort, model_rd, alu, wr});
                if (abort) exp_err = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
            got = {out_RegWrite, out_MemtoReg, out_ReadData, out_ALU, out_WriteRegister};
            n_tests++;
            if (!e_stall) begin
                e_out = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (got !== e_out) begin
                    n_fail++; $display("FAIL memwb got=%h exp=%h", got, e_out);
                end
            end else if ({out_RegWrite, out_MemtoReg} !== 2'b00) begin
                n_fail++; $display("FAIL bubble got=%b%b exp=00", out_RegWrite, out_MemtoReg);
            end
            k++;
        end while (e_stall && k < 200);
        dmem_bus.dmem_ack = 0;
    endtask

    task automatic check_stalls(input string name, input int got, input int expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, got, expv);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({dmem_bus.dmem_req, stall, out_RegWrite, out_MemtoReg, out_ReadData, out_ALU,
             out_WriteRegister, mem_error} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got nonzero req=%b stall=%b rw=%b err=%b",
                               dmem_bus.dmem_req, stall, out_RegWrite, mem_error);
        end
        n_tests++;
        if (dbg_state !== IDLE) begin
            n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
        end
        rst_n = 1;
    endtask

    task automatic test_zero_wait_load();
        int s;
        run_instr(1, 0, 1, 1, 32'h100, 32'h0, 5'd3, 0, 32'hDEADBEEF, s);
        check_stalls("zero_wait_load", s, 0);
    endtask

    task automatic test_store_wait();
        int s;
        run_instr(0, 1, 0, 0, 32'h200, 32'hCAFEF00D, 5'd0, 3, 32'h0, s);
        check_stalls("store_wait3", s, 3);
    endtask

    task automatic test_redirect();
        int s;
        in_Branch = 1; in_Zero = 1; in_Adder = 32'h40;
        run_instr(0, 0, 1, 0, 32'h11, 32'h0, 5'd4, -1, 32'h0, s);
        in_Zero = 0;
        run_instr(0, 0, 1, 0, 32'h12, 32'h0, 5'd4, -1, 32'h0, s);
        in_Jump = 1; in_AddFour = 32'h30000004; in_JumpAddress = 28'h0000100;
        run_instr(0, 0, 0, 0, 32'h13, 32'h0, 5'd0, -1, 32'h0, s);
        in_Jump = 0; in_Zero = 1;
        run_instr(1, 0, 1, 1, 32'h300, 32'h0, 5'd5, 2, 32'h55AA55AA, s);
        check_stalls("branch_load", s, 2);
        in_Branch = 0; in_Zero = 0; in_Adder = '0; in_AddFour = '0; in_JumpAddress = '0;
    endtask

    task automatic test_misaligned();
        int s;
        run_instr(1, 0, 1, 1, 32'h102, 32'h0, 5'd6, 1, 32'h0BADF00D, s);
`ifdef MEM_ALIGN_CHECK_EN
        check_stalls("misaligned", s, 0);
`else
        check_stalls("misaligned", s, 1);
`endif
    endtask

    task automatic test_ack_ignored();
        int s;
        run_instr(0, 0, 1, 0, 32'h44, 32'h0, 5'd7, 0, 32'h12345678, s);
        check_stalls("ack_ignored", s, 0);
    endtask

    task automatic test_back_to_back();
        int s, kind, dly;
        logic [31:0] a;
        for (int i = 0; i < 12; i++) begin
            kind = $urandom_range(0, 2);
            dly  = $urandom_range(0, 4);
            a    = $urandom() & 32'hFFFF_FFFC;
            run_instr(kind == 1, kind == 2, kind != 2, kind == 1, a, $urandom(),
                      5'($urandom_range(0, 31)), dly, $urandom(), s);
            check_stalls("b2b", s, (kind == 0) ? 0 : dly);
        end
    endtask

    task automatic test_timeout();
        int s;
        run_instr(1, 0, 1, 1, 32'h400, 32'h0, 5'd9, -1, 32'h0, s);
        check_stalls("timeout", s, TO);
        run_instr(0, 0, 1, 0, 32'h8, 32'h0, 5'd10, -1, 32'h0, s);
        check_stalls("after_timeout", s, 0);
    endtask

    task automatic test_reset_mid_wait();
        int s;
        in_MemRead = 1; in_RegWrite = 1; in_MemtoReg = 1; in_ALU = 32'h500;
        in_WriteRegister = 5'd11; dmem_bus.dmem_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (dbg_state !== WAIT) begin
            n_fail++; $display("FAIL midwait_state got=%0d exp=%0d", dbg_state, WAIT);
        end
        rst_n = 0;
        #1;
        n_tests++;
        if ({dmem_bus.dmem_req, stall, pc_redirect, out_RegWrite, out_MemtoReg, out_ReadData,
             out_ALU, out_WriteRegister, mem_error} !== '0) begin
            n_fail++; $display("FAIL async_reset got req=%b stall=%b rw=%b rd=%h err=%b",
                               dmem_bus.dmem_req, stall, out_RegWrite, out_ReadData, mem_error);
        end
        @(posedge clk); #1;
        clear_inputs();
        rst_n = 1;
        exp_q.delete(); model_rd = '0; exp_err = 1'b0;
        #1;
        n_tests++;
        if ({dbg_state, dmem_bus.dmem_req} !== {IDLE, 1'b0}) begin
            n_fail++; $display("FAIL post_reset state/req got=%0d/%b exp=%0d/0", dbg_state,
                               dmem_bus.dmem_req, IDLE);
        end
        run_instr(1, 0, 1, 1, 32'h104, 32'h0, 5'd12, 1, 32'hA5A5A5A5, s);
        check_stalls("post_reset_load", s, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_zero_wait_load();
        test_store_wait();
        test_redirect();
        test_misaligned();
        test_ack_ignored();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
